// File: rtl/dc9_if.sv
// Control/status bundle between a loop controller and the dc9 down-counter.
// The controller side is master; the counter itself is slave.
interface dc9_if #(
    parameter int WIDTH = 9
);
    logic             load;
    logic [WIDTH-1:0] d;
    logic             start;
    logic             dec;
    logic             stop;
    logic             ack;
    logic [WIDTH-1:0] q;
    logic             zero;
    logic             busy;
    logic             done;
    logic             tc;

    modport master (
        output load, d, start, dec, stop, ack,
        input  q, zero, busy, done, tc
    );

    modport slave (
        input  load, d, start, dec, stop, ack,
        output q, zero, busy, done, tc
    );
endinterface

// File: rtl/dc9.sv
// Loadable down-counter with run/done handshake, terminal-count pulse and
// optional auto-reload from a separately writable reload register.
module dc9 #(
    parameter int WIDTH  = 9,
    parameter int RELOAD = 0
) (
    input  logic   sys_clk,
    input  logic   reset,
    dc9_if.slave   bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [WIDTH-1:0] COUNT_ONE = WIDTH'(1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] q_r, q_nxt;
    logic [WIDTH-1:0] rl_r, rl_nxt;
    logic             tc_r, tc_nxt;
    logic [WIDTH-1:0] start_count;

    // With load and start together the new value, not the old q, decides RUN vs DONE.
    assign start_count = bus.load ? bus.d : q_r;

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latch).
    always_comb begin
        state_nxt = state;
        q_nxt     = q_r;
        rl_nxt    = rl_r;
        tc_nxt    = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (bus.load) begin
                    q_nxt  = bus.d;
                    rl_nxt = bus.d;
                end
                if (bus.start) begin
                    state_nxt = (start_count != '0) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                if (bus.load) begin
                    rl_nxt = bus.d;
                end
                if (bus.stop) begin
                    state_nxt = S_IDLE;
                end else if (bus.dec) begin
                    if (q_r > COUNT_ONE) begin
                        q_nxt = q_r - COUNT_ONE;
                    end else begin
                        // Reload takes rl_r as it stood before this edge; a same-cycle load waits.
                        tc_nxt = 1'b1;
                        if (RELOAD != 0 && rl_r != '0) begin
                            q_nxt = rl_r;
                        end else begin
                            q_nxt     = '0;
                            state_nxt = S_DONE;
                        end
                    end
                end
            end
            S_DONE: begin
                if (bus.ack) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments; reset is synchronous and wins over everything.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state <= S_IDLE;
            q_r   <= '0;
            rl_r  <= '0;
            tc_r  <= 1'b0;
        end else begin
            state <= state_nxt;
            q_r   <= q_nxt;
            rl_r  <= rl_nxt;
            tc_r  <= tc_nxt;
        end
    end

    assign bus.q    = q_r;
    assign bus.zero = (q_r == '0);
    assign bus.busy = (state == S_RUN);
    assign bus.done = (state == S_DONE);
    assign bus.tc   = tc_r;
endmodule

// File: doc/dc9.md
# dc9

Loadable 9-bit down-counter with run/done handshake: the decrementing counterpart to the `ha9` incrementer, for TOM inner-loop and line-length counts. A controller loads a count, starts it, and strobes `dec` once per processed item. The block flags terminal count, optionally reloads, and holds `done` until acknowledged.

## Interface
- `WIDTH`, 9, counter width in bits.
- `RELOAD`, 0, 1 = on terminal count reload from the reload register and keep running; 0 = stop in DONE.
- `sys_clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `load`  in  1  write `d` (see Operation).
- `d`  in  WIDTH  load value.
- `start`  in  1  begin counting (IDLE only).
- `dec`  in  1  decrement request (RUN only).
- `stop`  in  1  abort (RUN only).
- `ack`  in  1  acknowledge completion (DONE only).
- `q`  out  WIDTH  current count (registered).
- `zero`  out  1  `q == 0` (combinational from `q`).
- `busy`  out  1  state is RUN.
- `done`  out  1  state is DONE.
- `tc`  out  1  registered one-cycle terminal-count pulse.

## Operation
- States: IDLE, RUN, DONE.
- Reset: state IDLE, `q`=0, reload register `rl`=0, `tc`=0, `busy`=0, `done`=0, `zero`=1.
- `load`:
  - In IDLE it writes `q`←`d` and `rl`←`d`.
  - In RUN it writes `rl` only; `q` is untouched.
  - In DONE it is ignored.
- IDLE:
  - `start` with effective count ≠0 → RUN.
  - `start` with effective count =0 → DONE directly; no `tc`.
  - When `load` and `start` coincide, the effective count is `d`, which is also written to `q`/`rl`.
  - Otherwise the effective count is `q`.
  - `dec`, `stop` and `ack` are ignored.
- RUN, priority order:
  - `stop` → IDLE; `q` holds its current value; no `tc`.
  - `dec` with `q`>1: `q`←`q`−1.
  - `dec` with `q`==1 (terminal): `tc`=1 next cycle.
    - RELOAD=0: `q`←0 and state → DONE.
    - RELOAD=1 and `rl`≠0: `q`←`rl` and stay in RUN.
    - RELOAD=1 and `rl`==0: `q`←0 and → DONE.
  - Reload uses the `rl` value as it stands before that cycle's edge. A `load` in the same cycle affects the next reload only.
- DONE: `ack` → IDLE; `q` stays 0. `load`, `start`, `dec` and `stop` are ignored, and `done` holds until `ack`.
- Arithmetic: unsigned. `q` never decrements from 0 (unreachable in RUN), so no wrap-around occurs.
- `reset` asserted in any state, including mid-RUN, returns everything to reset values on that edge and overrides all other inputs.

## Timing
- `q`, `busy`, `done` and `tc` are registered and change one edge after the causing input is sampled.
- `zero` follows `q` combinationally.
- Decrement latency is 1 cycle. Maximum rate is one `dec` per cycle, back-to-back, with no bubble across a reload.
- `tc` is high for exactly one cycle per terminal event. On that cycle `q` already shows 0 (or the reloaded value), and `busy`/`done` already reflect the next state.
- `start`→`busy`: 1 cycle. Terminal `dec`→`done`: 1 cycle. `ack`→`done` low: 1 cycle.

## Test plan
- Reset check: drive `reset` for 2 cycles with random inputs. Expect `q`=0, `zero`=1 and `busy`/`done`/`tc`=0.
- Basic count, RELOAD=0:
  - Load 3, then `start`; `busy`=1 one cycle later.
  - Drive 3 back-to-back `dec`: `q`=2,1,0.
  - `tc` and `done` rise on the third edge; `tc` lasts one cycle.
  - `ack` → IDLE with `done`=0.
- Zero-length count: load 0 + `start` in the same cycle → DONE next cycle, `busy` never high, `tc` never high.
- Auto-reload, RELOAD=1:
  - Load 2, `start`, then 5 continuous `dec`: `q`=1,0→2 (tc),1,2 (tc)… i.e. sequence 1,2,1,2 with `tc` on cycles 2 and 4.
  - `load` of 4 during RUN: next reload gives 4.
- Boundary value: load 511 (0x1FF), `start`, 511 `dec` with random gaps. `q` reaches 0 exactly on the 511th `dec`, and `dec` in gaps or in DONE has no effect.
- Abort and mid-run reset:
  - `stop` with `q`=5 → IDLE, `q`=5.
  - Restart, then assert `reset` mid-RUN → all reset values on that edge, even with `dec`/`load` asserted simultaneously.
